// File: rtl/common_pkg.sv
// Shared fetch-path types and constants.
package common;

  localparam int unsigned ADDR_WIDTH        = 32;
  localparam int unsigned INSTRUCTION_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]        pc;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is presented combinationally from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot the push writes into, so push-when-full is legal with a pop.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Credit-based instruction fetch: issues sequential requests, buffers in-order responses,
// and discards responses that were in flight when a redirect arrived.
module instr_fetch
  import common::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned           BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [INSTRUCTION_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0]        id_pc
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       stale_q, stale_d;

  logic [CntW-1:0]       buf_count;
  logic                  buf_empty;
  logic [CntW:0]         credits_used;
  logic                  req_fire;
  logic                  buf_push;
  logic                  buf_pop;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign credits_used   = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst && (state_q == RUN) && !redirect_valid &&
                          (credits_used < (CntW + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // In RUN every outstanding request is sequential and ends just below pc_q, so the
  // oldest (the one responding now) sits outstanding_q words back.
  assign rsp_pc = pc_q - (ADDR_WIDTH'(outstanding_q) << 2);

  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};
  assign buf_push   = (state_q == RUN) && imem_rsp_valid && !redirect_valid;
  assign buf_pop    = id_valid && id_ready && !redirect_valid;

  assign id_valid       = !rst && !buf_empty;
  assign id_instruction = rst ? '0 : head_entry.instr;
  assign id_pc          = rst ? '0 : head_entry.pc;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (buf_pop),
    .pop_data  (head_entry),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (req_fire) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    if (redirect_valid) begin
      // A response landing in the redirect cycle is dropped right now, so it is not stale.
      stale_d = outstanding_q - CntW'(imem_rsp_valid);
      state_d = (stale_d != '0) ? FLUSH : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          state_d = RUN;
        end
        FLUSH: begin
          if (imem_rsp_valid) begin
            stale_d = stale_q - CntW'(1);
            if (stale_d == '0) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries, which is also the in-flight credit limit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: in-order response valid, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data, input, INSTRUCTION_WIDTH bits: fetched instruction.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect, one-cycle pulse.
REQ-011 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-012 SHALL have port id_valid, output, 1 bit: an instruction is presented to decode.
REQ-013 SHALL have port id_ready, input, 1 bit: decode consumes.
REQ-014 SHALL have port id_instruction, output, INSTRUCTION_WIDTH bits: instruction to decode.
REQ-015 SHALL have port id_pc, output, 32 bits: PC of id_instruction.

Function
REQ-016 SHALL implement FSM states RUN and FLUSH: RUN->FLUSH on redirect with stale>0; FLUSH->RUN when stale reaches 0; otherwise remain in the current state.
REQ-017 SHALL assert imem_req_valid iff state==RUN && !redirect_valid && (outstanding+buf_count)<BUF_DEPTH.
REQ-018 SHALL drive imem_req_addr = pc, and SHALL advance pc by 4 (mod 2^32, 0xFFFF_FFFC->0x0000_0000) on each accepted request.
REQ-019 SHALL allow withdrawal of imem_req_valid when redirect_valid asserts; the memory port tolerates withdrawal.
REQ-020 SHALL track outstanding (0..BUF_DEPTH): +1 on accept, -1 on response, net 0 when both occur in the same cycle.
REQ-021 SHALL, in RUN, push {imem_rsp_data, its request address} into the buffer on imem_rsp_valid; credit rules guarantee no overflow.
REQ-022 SHALL present the buffer head on id_* outputs, with id_valid = buf_count!=0, and SHALL pop on id_valid&&id_ready.
REQ-023 SHALL make a response accepted in cycle N visible on id_valid no earlier than N+1 (registered buffer, no bypass).
REQ-024 SHALL support simultaneous push and pop, including when full: count unchanged, order preserved.
REQ-025 SHALL, on redirect_valid, in the same edge: flush the buffer, set pc = {redirect_pc[31:2],2'b00}, and set stale = outstanding - imem_rsp_valid.
REQ-026 SHALL give redirect priority over a same-cycle pop and a same-cycle push, so id_valid=0 the next cycle.
REQ-027 SHALL, in FLUSH, drop each response and decrement stale, and SHALL issue no requests.
REQ-028 SHALL, on redirect during FLUSH, update pc and recompute stale per REQ-025, remaining in FLUSH if stale>0.
REQ-029 SHALL never present the same instruction twice nor skip a PC between redirects.

Reset
REQ-030 SHALL, while rst=1, reset: pc=RESET_PC, state=RUN, outstanding=0, stale=0, buf_count=0, imem_req_valid=0, id_valid=0.
REQ-031 SHALL drive id_instruction and id_pc to 0 in reset.
REQ-032 SHALL raise imem_req_valid with addr=RESET_PC in the first cycle after rst deasserts.
REQ-033 SHALL, on reset mid-operation, discard in-flight state; the memory is reset concurrently.

Structure
REQ-034 SHALL place ADDR_WIDTH (32), RESET_PC default, and the fetch_state_t enum {RUN, FLUSH} in package common, alongside INSTRUCTION_WIDTH.
REQ-035 SHALL implement the buffer as sub-module fetch_fifo (synchronous FIFO with flush, parametrised width and depth).

Verification
REQ-036 SHALL cover: reset, memory always ready, 1-cycle latency, id_ready=1 -> id_pc sequence 0x0,0x4,0x8,... at one per cycle after fill.
REQ-037 SHALL cover: id_ready=0 for 10 cycles -> exactly 2 requests issued, buffer holds PC 0x0/0x4, no further requests; release -> in-order delivery.
REQ-038 SHALL cover: redirect to 0x100 with 2 outstanding -> both responses dropped, FLUSH for 2 responses, next id_pc=0x100.
REQ-039 SHALL cover: redirect_pc=0x203 -> fetch address 0x200.
REQ-040 SHALL cover: pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-041 SHALL cover: redirect same cycle as pop, response and a full buffer -> id_valid=0 next cycle, stale=outstanding-1, no duplicate delivered.
